// File: rtl/hog_framer_pkg.sv
// Shared types and constants for the HLS result framer.
// Holds the frame FSM state encoding, the word and count widths, and the default header magic.
package hog_framer_pkg;
   localparam int WORD_W = 32;
   localparam int CNT_W = 16;
   localparam logic [15:0] DEFAULT_MAGIC = 16'hF00D;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2,
      TRAILER = 2'd3
   } framer_state_t;
endpackage

// File: rtl/hls_result_framer_checksum.sv
// Payload checksum accumulator: a 16-bit wrapping sum of the upper and lower halves of each word.
// The framer instantiates it only when HLS_RESULT_FRAMER_CHECKSUM_EN is defined.
module frame_checksum
   import hog_framer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              add_en,
   input  logic [WORD_W-1:0] din,
   output logic [CNT_W-1:0]  sum
);
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         sum <= '0;
      end else if (add_en) begin
         sum <= sum + din[31:16] + din[15:0];
      end
   end
endmodule

// File: rtl/hls_result_framer.sv
// Frames HLS result words as header / payload / trailer and closes partial frames on an idle timeout.
// Define HLS_RESULT_FRAMER_CHECKSUM_EN to fill the trailer checksum field; otherwise it reads 16'h0000.
module hls_result_framer
   import hog_framer_pkg::*;
#(
   parameter int          FRAME_LEN = 64,
   parameter int          TIMEOUT   = 1024,
   parameter logic [15:0] MAGIC     = DEFAULT_MAGIC
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic [WORD_W-1:0]   out_r_din,
   input  logic                out_r_write,
   output logic                out_r_full_n,
   output logic [WORD_W-1:0]   fifo_din,
   output logic                fifo_wr_en,
   input  logic                fifo_full,
   output logic [CNT_W-1:0]    frame_seq,
   output logic                proto_err,
   output framer_state_t       fsm_state
);
   localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  LEN_LAST  = CNT_W'(FRAME_LEN);

   framer_state_t     state, next_state;
   logic [WORD_W-1:0] hold_data;
   logic              hold_valid;
   logic              drain, accept;
   logic [CNT_W-1:0]  count, count_n;
   logic [CNT_W-1:0]  seq_n;
   logic [CNT_W-1:0]  checksum;
   logic [IDLE_W-1:0] idle_cnt;
   logic              wr_en_n;
   logic [WORD_W-1:0] din_n;

   // valid/ready: a word transfers on any rising edge where out_r_write && out_r_full_n.
   assign drain        = (state == PAYLOAD) && hold_valid && !fifo_full;
   assign out_r_full_n = ap_rst_n && (!hold_valid || drain);
   assign accept       = out_r_write && out_r_full_n;
   assign fsm_state    = state;

`ifdef HLS_RESULT_FRAMER_CHECKSUM_EN
   logic csum_clr;
   assign csum_clr = (state == TRAILER) && !fifo_full;
   frame_checksum u_checksum (
      .clk    (ap_clk),
      .rst_n  (ap_rst_n),
      .clr    (csum_clr),
      .add_en (drain),
      .din    (hold_data),
      .sum    (checksum)
   );
`else
   assign checksum = '0;
`endif

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (accept) begin
         hold_valid <= 1'b1;
         hold_data  <= out_r_din;
      end else if (drain) begin
         hold_valid <= 1'b0;
      end
   end

   // Idle counter saturates so a long stall cannot wrap it back below the timeout.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n || state != PAYLOAD || accept) begin
         idle_cnt <= '0;
      end else if (idle_cnt != IDLE_LAST) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         proto_err <= 1'b0;
      end else if (out_r_write && !out_r_full_n) begin
         proto_err <= 1'b1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state      <= IDLE;
         fifo_wr_en <= 1'b0;
         fifo_din   <= '0;
         count      <= '0;
         frame_seq  <= '0;
      end else begin
         state      <= next_state;
         fifo_wr_en <= wr_en_n;
         fifo_din   <= din_n;
         count      <= count_n;
         frame_seq  <= seq_n;
      end
   end

   always_comb begin
      next_state = state;
      wr_en_n    = 1'b0;
      din_n      = fifo_din;
      count_n    = count;
      seq_n      = frame_seq;
      case (state)
         IDLE: begin
            if (hold_valid) next_state = HEADER;
         end
         HEADER: begin
            if (!fifo_full) begin
               wr_en_n    = 1'b1;
               din_n      = {MAGIC, frame_seq};
               next_state = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (drain) begin
               wr_en_n = 1'b1;
               din_n   = hold_data;
               count_n = count + 1'b1;
               if (count_n == LEN_LAST) next_state = TRAILER;
            end else if (!hold_valid && idle_cnt == IDLE_LAST) begin
               next_state = TRAILER;
            end
         end
         TRAILER: begin
            if (!fifo_full) begin
               wr_en_n    = 1'b1;
               din_n      = {count, checksum};
               seq_n      = frame_seq + 1'b1;
               count_n    = '0;
               next_state = hold_valid ? HEADER : IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end
endmodule

// File: tb/tb_hls_result_framer.sv
// Self-checking bench for hls_result_framer: frame-level reference model feeding an expected queue,
// with a monitor that pops and compares every FIFO write.
module tb_hls_result_framer;
   import hog_framer_pkg::*;

   localparam int FL = 4;
   localparam int TO = 16;
   localparam logic [15:0] MAG = DEFAULT_MAGIC;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic [31:0]   out_r_din = '0;
   logic          out_r_write = 1'b0;
   logic          out_r_full_n;
   logic [31:0]   fifo_din;
   logic          fifo_wr_en;
   logic          fifo_full = 1'b0;
   logic [15:0]   frame_seq;
   logic          proto_err;
   framer_state_t fsm_state;

   hls_result_framer #(.FRAME_LEN(FL), .TIMEOUT(TO), .MAGIC(MAG)) dut (
      .ap_clk       (ap_clk),
      .ap_rst_n     (ap_rst_n),
      .out_r_din    (out_r_din),
      .out_r_write  (out_r_write),
      .out_r_full_n (out_r_full_n),
      .fifo_din     (fifo_din),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_full    (fifo_full),
      .frame_seq    (frame_seq),
      .proto_err    (proto_err),
      .fsm_state    (fsm_state)
   );

   // clock/reset
   always #5 ap_clk = ~ap_clk;
   int cyc = 0;
   always @(posedge ap_clk) cyc <= cyc + 1;

   // scoreboard state
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];
   int          m_cnt = 0;
   logic [15:0] m_sum = '0;
   logic [15:0] m_seq = '0;
   int          last_acc_cyc = 0;
   int          last_wr_cyc = 0;
   bit          rand_stall = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // reference model: frame structure derived from the accepted word sequence
   function automatic void model_close();
      if (m_cnt > 0) begin
         exp_q.push_back({16'(m_cnt), m_sum});
         m_seq = m_seq + 16'd1;
         m_cnt = 0;
         m_sum = '0;
      end
   endfunction

   function automatic void model_accept(input logic [31:0] d);
      if (m_cnt == 0) exp_q.push_back({MAG, m_seq});
      exp_q.push_back(d);
      m_cnt++;
`ifdef HLS_RESULT_FRAMER_CHECKSUM_EN
      m_sum = m_sum + d[31:16] + d[15:0];
`endif
      if (m_cnt == FL) model_close();
   endfunction

   function automatic void model_reset();
      m_cnt = 0;
      m_sum = '0;
      m_seq = '0;
      exp_q.delete();
   endfunction

   // monitor
   always @(negedge ap_clk) begin
      logic [31:0] e;
      if (fifo_wr_en) begin
         last_wr_cyc = cyc;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write actual=%h required=no_write", fifo_din);
         end else begin
            e = exp_q.pop_front();
            check("stream", fifo_din, e);
         end
      end
   end

   // random backpressure, short pulses only
   initial begin
      forever begin
         @(negedge ap_clk);
         if (rand_stall && $urandom_range(0, 7) == 0) begin
            fifo_full = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge ap_clk);
            fifo_full = 1'b0;
         end
      end
   end

   // driver: called at a negedge, returns at the negedge after the accepting edge
   task automatic send(input logic [31:0] d);
      logic ok;
      bit done;
      done = 1'b0;
      out_r_din = d;
      out_r_write = 1'b1;
      for (int i = 0; i < 500 && !done; i++) begin
         #1 ok = out_r_full_n;
         @(posedge ap_clk);
         @(negedge ap_clk);
         if (ok) done = 1'b1;
      end
      out_r_write = 1'b0;
      if (done) begin
         last_acc_cyc = cyc;
         model_accept(d);
      end else begin
         total++;
         bad++;
         $display("FAIL send_timeout actual=not_accepted required=accepted data=%h", d);
      end
   endtask

   task automatic wait_empty(input string name);
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge ap_clk);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int d;
      int len;
      // reset state
      repeat (3) @(negedge ap_clk);
      #1;
      check("rst_full_n", 32'(out_r_full_n), 32'd0);
      check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("rst_din", fifo_din, 32'd0);
      check("rst_seq", 32'(frame_seq), 32'd0);
      check("rst_proto", 32'(proto_err), 32'd0);
      check("rst_state", 32'(fsm_state), 32'(IDLE));
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);

      // two full frames back to back
      for (int i = 1; i <= 8; i++) send(32'(i));
      wait_empty("two_frames");
      check("seq_after_two", 32'(frame_seq), 32'(m_seq));

      // idle timeout closes a partial frame
      send(32'd5);
      send(32'd6);
      model_close();
      wait_empty("timeout_frame");
      d = last_wr_cyc - last_acc_cyc;
      check("timeout_latency_ok", 32'(d >= 16 && d <= 17), 32'd1);
      repeat (2) @(negedge ap_clk);
      check("timeout_idle", 32'(fsm_state), 32'(IDLE));

      // fixed 10-cycle stall under continuous writes
      fork
         begin
            for (int i = 0; i < 16; i++) send(32'h0100_0000 + 32'(i * 3));
         end
         begin
            repeat (6) @(negedge ap_clk);
            fifo_full = 1'b1;
            for (int k = 1; k < 10; k++) begin
               @(negedge ap_clk);
               #2 check("stall_full_n", 32'(out_r_full_n), 32'd0);
            end
            @(negedge ap_clk);
            fifo_full = 1'b0;
         end
      join
      model_close();
      wait_empty("stall_stream");

      // random bursts with random backpressure
      rand_stall = 1'b1;
      for (int b = 0; b < 12; b++) begin
         len = $urandom_range(1, 10);
         for (int w = 0; w < len; w++) begin
            send($urandom);
            repeat ($urandom_range(0, 2)) @(negedge ap_clk);
         end
         model_close();
         wait_empty("random_burst");
      end
      rand_stall = 1'b0;
      repeat (8) @(negedge ap_clk);
      fifo_full = 1'b0;

      // reset mid-frame drops the frame without a trailer
      send(32'hAAAA_0001);
      send(32'hAAAA_0002);
      wait_empty("pre_reset");
      ap_rst_n = 1'b0;
      #1 check("reset_full_n", 32'(out_r_full_n), 32'd0);
      model_reset();
      @(negedge ap_clk);
      check("reset_seq", 32'(frame_seq), 32'd0);
      check("reset_wr_en", 32'(fifo_wr_en), 32'd0);
      ap_rst_n = 1'b1;
      repeat (30) @(negedge ap_clk);
      for (int i = 0; i < 3; i++) send(32'h0000_0010 + 32'(i));
      model_close();
      wait_empty("post_reset_frame");

      // protocol error: write while not ready
      fifo_full = 1'b1;
      send(32'h0000_0011);
      #1 check("busy_full_n", 32'(out_r_full_n), 32'd0);
      out_r_din = 32'hDEAD_BEEF;
      out_r_write = 1'b1;
      @(negedge ap_clk);
      out_r_write = 1'b0;
      #1 check("proto_set", 32'(proto_err), 32'd1);
      fifo_full = 1'b0;
      model_close();
      wait_empty("proto_stream");
      check("proto_sticky", 32'(proto_err), 32'd1);
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      model_reset();
      @(negedge ap_clk);
      check("proto_clear", 32'(proto_err), 32'd0);
      ap_rst_n = 1'b1;
      repeat (4) @(negedge ap_clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
